// File: rtl/multichannel_demodulator.sv
// Multichannel I/Q demodulator: per-channel block accumulation of s*cos / s*sin
// followed by an alpha-max/beta-min magnitude. Optional DEMOD_IQ_OUT_EN exports the block sums.
module multichannel_demodulator #(
  parameter int WIDTH_DATA    = 10,
  parameter int WIDTH_SIN_COS = 9,
  parameter int CHANNELS      = 4,
  parameter int WIDTH_CH      = 2,
  parameter int LOG2_N        = 6,
  parameter int WIDTH_AMP     = 10,
  localparam int PROD_W       = WIDTH_DATA + WIDTH_SIN_COS,
  localparam int ACC_W        = PROD_W + LOG2_N
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic [WIDTH_DATA-1:0]           data,
  input  logic [WIDTH_CH-1:0]             ch,
  input  logic signed [WIDTH_SIN_COS-1:0] sin,
  input  logic signed [WIDTH_SIN_COS-1:0] cos,
  input  logic                            restart,
  output logic [WIDTH_AMP-1:0]            amp,
  output logic [WIDTH_CH-1:0]             amp_ch,
  output logic                            amp_valid,
  output logic                            err_ch
`ifdef DEMOD_IQ_OUT_EN
  ,
  output logic signed [ACC_W-1:0]         i_sum,
  output logic signed [ACC_W-1:0]         q_sum
`endif
);

  logic                     ch_ok;
  logic signed [WIDTH_DATA-1:0] s_smp;
  logic signed [PROD_W-1:0] prod_i, prod_q;

  logic                     s1_valid_q, s1_valid_d;
  logic [WIDTH_CH-1:0]      s1_ch_q, s1_ch_d;
  logic signed [PROD_W-1:0] p_i_q, p_i_d, p_q_q, p_q_d;
  logic                     err_ch_q, err_ch_d;

  logic [LOG2_N-1:0]        cnt_q   [CHANNELS];
  logic [LOG2_N-1:0]        cnt_d   [CHANNELS];
  logic signed [ACC_W-1:0]  acc_i_q [CHANNELS];
  logic signed [ACC_W-1:0]  acc_i_d [CHANNELS];
  logic signed [ACC_W-1:0]  acc_q_q [CHANNELS];
  logic signed [ACC_W-1:0]  acc_q_d [CHANNELS];
  logic signed [ACC_W-1:0]  dump_i_q, dump_i_d, dump_q_q, dump_q_d;
  logic [WIDTH_CH-1:0]      dump_ch_q, dump_ch_d;
  logic                     dump_valid_q, dump_valid_d;

  logic [ACC_W-1:0]         abs_i, abs_q, mx, mn, mag;
  logic [WIDTH_AMP-1:0]     amp_q, amp_d;
  logic [WIDTH_CH-1:0]      amp_ch_q, amp_ch_d;
  logic                     amp_valid_q, amp_valid_d;
`ifdef DEMOD_IQ_OUT_EN
  logic signed [ACC_W-1:0]  i_sum_q, i_sum_d, q_sum_q, q_sum_d;
`endif

  // Offset-binary to two's complement is just an MSB flip.
  always_comb begin
    ch_ok  = int'(ch) < CHANNELS;
    s_smp  = $signed({~data[WIDTH_DATA-1], data[WIDTH_DATA-2:0]});
    prod_i = PROD_W'(s_smp) * PROD_W'(cos);
    prod_q = PROD_W'(s_smp) * PROD_W'(sin);
  end

  always_comb begin
    s1_valid_d = en & ch_ok & ~restart;
    s1_ch_d    = en ? ch : s1_ch_q;
    p_i_d      = en ? prod_i : p_i_q;
    p_q_d      = en ? prod_q : p_q_q;
    err_ch_d   = restart ? 1'b0 : (err_ch_q | (en & ~ch_ok));
  end

  // Only the matching channel moves; the last sample of a block goes straight into the dump.
  always_comb begin
    dump_i_d     = dump_i_q;
    dump_q_d     = dump_q_q;
    dump_ch_d    = dump_ch_q;
    dump_valid_d = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_d[c]   = cnt_q[c];
      acc_i_d[c] = acc_i_q[c];
      acc_q_d[c] = acc_q_q[c];
      if (restart) begin
        cnt_d[c]   = '0;
        acc_i_d[c] = '0;
        acc_q_d[c] = '0;
      end else if (s1_valid_q && s1_ch_q == WIDTH_CH'(c)) begin
        if (cnt_q[c] == {LOG2_N{1'b1}}) begin
          dump_i_d     = acc_i_q[c] + ACC_W'(p_i_q);
          dump_q_d     = acc_q_q[c] + ACC_W'(p_q_q);
          dump_ch_d    = s1_ch_q;
          dump_valid_d = 1'b1;
          cnt_d[c]     = '0;
          acc_i_d[c]   = '0;
          acc_q_d[c]   = '0;
        end else begin
          cnt_d[c]   = cnt_q[c] + LOG2_N'(1);
          acc_i_d[c] = acc_i_q[c] + ACC_W'(p_i_q);
          acc_q_d[c] = acc_q_q[c] + ACC_W'(p_q_q);
        end
      end
    end
  end

  // mag ~= max + 3/8 min.
  always_comb begin
    abs_i       = dump_i_q[ACC_W-1] ? ACC_W'(-dump_i_q) : ACC_W'(dump_i_q);
    abs_q       = dump_q_q[ACC_W-1] ? ACC_W'(-dump_q_q) : ACC_W'(dump_q_q);
    mx          = (abs_i >= abs_q) ? abs_i : abs_q;
    mn          = (abs_i >= abs_q) ? abs_q : abs_i;
    mag         = mx + (mn >> 2) + (mn >> 3);
    amp_valid_d = dump_valid_q & ~restart;
    amp_d       = amp_valid_d ? mag[ACC_W-1 -: WIDTH_AMP] : amp_q;
    amp_ch_d    = amp_valid_d ? dump_ch_q : amp_ch_q;
`ifdef DEMOD_IQ_OUT_EN
    i_sum_d     = amp_valid_d ? dump_i_q : i_sum_q;
    q_sum_d     = amp_valid_d ? dump_q_q : q_sum_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_ch_q      <= '0;
      p_i_q        <= '0;
      p_q_q        <= '0;
      err_ch_q     <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c]   <= '0;
        acc_i_q[c] <= '0;
        acc_q_q[c] <= '0;
      end
      dump_i_q     <= '0;
      dump_q_q     <= '0;
      dump_ch_q    <= '0;
      dump_valid_q <= 1'b0;
      amp_q        <= '0;
      amp_ch_q     <= '0;
      amp_valid_q  <= 1'b0;
`ifdef DEMOD_IQ_OUT_EN
      i_sum_q      <= '0;
      q_sum_q      <= '0;
`endif
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_ch_q      <= s1_ch_d;
      p_i_q        <= p_i_d;
      p_q_q        <= p_q_d;
      err_ch_q     <= err_ch_d;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c]   <= cnt_d[c];
        acc_i_q[c] <= acc_i_d[c];
        acc_q_q[c] <= acc_q_d[c];
      end
      dump_i_q     <= dump_i_d;
      dump_q_q     <= dump_q_d;
      dump_ch_q    <= dump_ch_d;
      dump_valid_q <= dump_valid_d;
      amp_q        <= amp_d;
      amp_ch_q     <= amp_ch_d;
      amp_valid_q  <= amp_valid_d;
`ifdef DEMOD_IQ_OUT_EN
      i_sum_q      <= i_sum_d;
      q_sum_q      <= q_sum_d;
`endif
    end
  end

  assign amp       = amp_q;
  assign amp_ch    = amp_ch_q;
  assign amp_valid = amp_valid_q;
  assign err_ch    = err_ch_q;
`ifdef DEMOD_IQ_OUT_EN
  assign i_sum     = i_sum_q;
  assign q_sum     = q_sum_q;
`endif

endmodule

// File: tb/tb_multichannel_demodulator.sv
// Directed bench for multichannel_demodulator (N=4, 3-bit channel index, 4 channels).
module tb_multichannel_demodulator;
  localparam int WD = 10, WS = 9, CHN = 4, WC = 3, L2N = 2, WA = 10;
  localparam int ACC_W = WD + WS + L2N;

  logic              clk, rst_n, en, restart;
  logic [WD-1:0]     data;
  logic [WC-1:0]     ch;
  logic signed [WS-1:0] sin_v, cos_v;
  logic [WA-1:0]     amp;
  logic [WC-1:0]     amp_ch;
  logic              amp_valid, err_ch;
`ifdef DEMOD_IQ_OUT_EN
  logic signed [ACC_W-1:0] i_sum, q_sum;
`endif

  multichannel_demodulator #(
    .WIDTH_DATA(WD), .WIDTH_SIN_COS(WS), .CHANNELS(CHN),
    .WIDTH_CH(WC), .LOG2_N(L2N), .WIDTH_AMP(WA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data), .ch(ch),
    .sin(sin_v), .cos(cos_v), .restart(restart),
    .amp(amp), .amp_ch(amp_ch), .amp_valid(amp_valid), .err_ch(err_ch)
`ifdef DEMOD_IQ_OUT_EN
    , .i_sum(i_sum), .q_sum(q_sum)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [WC+WA-1:0] exp_q[$];

  typedef struct {
    logic [WC-1:0] ch;
    logic [WD-1:0] data;
    logic signed [WS-1:0] cos_v;
    logic signed [WS-1:0] sin_v;
    int exp_amp;
    int exp_i;
    int exp_q;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: presents one sample, sampled at the next rising edge
  task automatic send(input logic [WC-1:0] c, input logic [WD-1:0] d,
                      input logic signed [WS-1:0] cv, input logic signed [WS-1:0] sv);
    en = 1'b1; ch = c; data = d; cos_v = cv; sin_v = sv;
    step();
    en = 1'b0;
  endtask

  // called just after the edge that sampled the last sample of a block
  task automatic check_latency(input string nm, input logic [WC-1:0] c,
                               input int a, input int ei, input int eq);
    chk({nm, "_valid_e0"}, amp_valid, 0);
    step();
    chk({nm, "_valid_e1"}, amp_valid, 0);
    step();
    chk({nm, "_valid_e2"}, amp_valid, 1);
    chk({nm, "_amp"}, amp, a);
    chk({nm, "_amp_ch"}, amp_ch, c);
`ifdef DEMOD_IQ_OUT_EN
    chk({nm, "_i_sum"}, longint'(i_sum), ei);
    chk({nm, "_q_sum"}, longint'(q_sum), eq);
`else
    if (ei == eq + ei - eq) begin end
`endif
    step();
    chk({nm, "_valid_e3"}, amp_valid, 0);
  endtask

  task automatic run_block(input string nm, input vec_t v);
    for (int k = 0; k < 4; k++) send(v.ch, v.data, v.cos_v, v.sin_v);
    exp_q.push_back({v.ch, WA'(v.exp_amp)});
    check_latency(nm, v.ch, v.exp_amp, v.exp_i, v.exp_q);
  endtask

  // scoreboard: every amp_valid pulse must match the oldest expected block
  always @(negedge clk) begin
    if (rst_n && amp_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_pulse", exp_q.size(), 1);
      end else begin
        logic [WC+WA-1:0] e;
        e = exp_q.pop_front();
        chk("sb_amp", amp, e[WA-1:0]);
        chk("sb_amp_ch", amp_ch, e[WC+WA-1:WA]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl[0] = '{ch: 3'd0, data: 10'd1023, cos_v: 9'sd255,  sin_v: 9'sd0,    exp_amp: 254, exp_i: 521220,  exp_q: 0};
    tbl[1] = '{ch: 3'd1, data: 10'd0,    cos_v: 9'sd255,  sin_v: 9'sd0,    exp_amp: 255, exp_i: -522240, exp_q: 0};
    tbl[2] = '{ch: 3'd2, data: 10'd1023, cos_v: 9'sd255,  sin_v: 9'sd255,  exp_amp: 349, exp_i: 521220,  exp_q: 521220};
    tbl[3] = '{ch: 3'd3, data: 10'd0,    cos_v: -9'sd256, sin_v: -9'sd256, exp_amp: 352, exp_i: 524288,  exp_q: 524288};

    rst_n = 1'b0; en = 1'b0; restart = 1'b0; data = '0; ch = '0; sin_v = '0; cos_v = '0;
    repeat (3) step();
    chk("rst_amp", amp, 0);
    chk("rst_amp_ch", amp_ch, 0);
    chk("rst_amp_valid", amp_valid, 0);
    chk("rst_err_ch", err_ch, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_block($sformatf("blk%0d", i), tbl[i]);

    // interleaved channels 0/1, back-to-back
    for (int k = 0; k < 8; k++) send(WC'(k % 2), 10'd1023, 9'sd255, 9'sd0);
    exp_q.push_back({3'd0, 10'd254});
    exp_q.push_back({3'd1, 10'd254});
    chk("ilv_valid_e0", amp_valid, 0);
    step();
    chk("ilv_valid_a", amp_valid, 1);
    chk("ilv_ch_a", amp_ch, 0);
    chk("ilv_amp_a", amp, 254);
    step();
    chk("ilv_valid_b", amp_valid, 1);
    chk("ilv_ch_b", amp_ch, 1);
    chk("ilv_amp_b", amp, 254);
    step();
    chk("ilv_valid_end", amp_valid, 0);

    // partial block, then restart together with a sample that must be dropped
    send(3'd0, 10'd0, 9'sd255, 9'sd0);
    send(3'd0, 10'd0, 9'sd255, 9'sd0);
    restart = 1'b1;
    send(3'd0, 10'd0, 9'sd255, 9'sd0);
    restart = 1'b0;
    chk("rs_amp_hold", amp, 254);
    chk("rs_amp_ch_hold", amp_ch, 1);
    chk("rs_valid", amp_valid, 0);
    run_block("rs_blk", tbl[0]);

    // out-of-range channel: flagged, dropped, no aliasing onto channel 1
    send(3'd5, 10'd0, 9'sd255, 9'sd0);
    chk("err_set_ch5", err_ch, 1);
    v = '{ch: 3'd1, data: 10'd1023, cos_v: 9'sd255, sin_v: 9'sd0, exp_amp: 254, exp_i: 521220, exp_q: 0};
    run_block("err_blk", v);
    chk("err_sticky", err_ch, 1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("err_cleared", err_ch, 0);
    send(3'd4, 10'd1023, 9'sd255, 9'sd0);
    chk("err_set_ch4", err_ch, 1);
    repeat (3) step();
    chk("err_no_pulse", amp_valid, 0);

    // asynchronous reset mid-block
    send(3'd0, 10'd1023, 9'sd255, 9'sd0);
    send(3'd0, 10'd1023, 9'sd255, 9'sd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_amp", amp, 0);
    chk("arst_amp_ch", amp_ch, 0);
    chk("arst_valid", amp_valid, 0);
    chk("arst_err", err_ch, 0);
`ifdef DEMOD_IQ_OUT_EN
    chk("arst_i_sum", longint'(i_sum), 0);
    chk("arst_q_sum", longint'(q_sum), 0);
`endif
    step();
    rst_n = 1'b1;
    run_block("post_rst", tbl[0]);

    repeat (4) step();
    chk("sb_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
